// File: rtl/sar_avg_sequencer.sv
// sar_avg_sequencer: paces SAR conversions, averages 2^LOG2_AVG results, emits them over valid/ready
//   clk_i/rst_ni            clock, async active-low reset
//   en_i, period_i          run enable, idle gap (cycles) after each eoc rise
//   sar_start_o/eoc_i/result_i  SAR engine handshake
//   data_o/valid_o/ready_i  averaged sample stream
//   ovf_o/clr_ovf_i         sticky dropped-sample flag and its clear
//   busy_o                  sequencer active
module sar_avg_sequencer #(
  parameter int WIDTH    = 6,
  parameter int LOG2_AVG = 2,
  parameter int PERIOD_W = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic [PERIOD_W-1:0] period_i,
  output logic                sar_start_o,
  input  logic                sar_eoc_i,
  input  logic [WIDTH-1:0]    sar_result_i,
  output logic [WIDTH-1:0]    data_o,
  output logic                valid_o,
  input  logic                ready_i,
  output logic                ovf_o,
  input  logic                clr_ovf_i,
  output logic                busy_o
);
  localparam int CW = LOG2_AVG > 0 ? LOG2_AVG : 1;
  localparam int AW = WIDTH + LOG2_AVG;
  localparam logic [CW-1:0] LAST = CW'((1 << LOG2_AVG) - 1);
  typedef enum logic [1:0] {IDLE, START, CONV, GAP} state_t;
  state_t r_state, w_next;
  logic                r_eoc_q;
  logic [AW-1:0]       r_acc;
  logic [CW-1:0]       r_cnt;
  logic [PERIOD_W-1:0] r_gap;
  logic [WIDTH-1:0]    r_data;
  logic                r_valid;
  logic                r_ovf;
  logic                w_rise;
  logic                w_take;
  logic                w_load;
  logic [AW-1:0]       w_acc_next;
  assign w_rise     = sar_eoc_i & ~r_eoc_q;
  assign w_take     = (r_state == CONV) & w_rise & en_i;
  assign w_load     = w_take & (r_cnt == LAST);
  assign w_acc_next = r_acc + AW'(sar_result_i);
  assign data_o     = r_data;
  assign valid_o    = r_valid;
  assign ovf_o      = r_ovf;
  assign busy_o     = r_state != IDLE;
  always_comb begin
    w_next      = r_state;
    sar_start_o = 1'b0;
    case (r_state)
      IDLE:  w_next = en_i ? START : IDLE;
      START: begin
        sar_start_o = en_i & sar_eoc_i;
        w_next      = !en_i ? IDLE : (sar_eoc_i ? CONV : START);
      end
      // a zero period skips GAP entirely so the next start follows the rise directly
      CONV:  w_next = !w_rise ? CONV : (!en_i ? IDLE : (period_i == '0 ? START : GAP));
      GAP:   w_next = !en_i ? IDLE : (r_gap == PERIOD_W'(1) ? START : GAP);
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_eoc_q <= 1'b0;
      r_gap   <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_eoc_q <= sar_eoc_i;
      if (r_state == CONV && w_rise) r_gap <= period_i;
      else if (r_state == GAP) r_gap <= r_gap - PERIOD_W'(1);
      // every exit to IDLE lands here, so parking in IDLE discards any partial average
      if (r_state == IDLE || w_load) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else if (w_take) begin
        r_acc <= w_acc_next;
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_load && (!r_valid || ready_i)) begin
        r_data  <= w_acc_next[LOG2_AVG +: WIDTH];
        r_valid <= 1'b1;
      end else if (r_valid && ready_i) begin
        r_valid <= 1'b0;
      end
      r_ovf <= (w_load & r_valid & ~ready_i) | (r_ovf & ~clr_ovf_i);
    end
  end
endmodule

// File: doc/sar_avg_sequencer.md
Name: sar_avg_sequencer

Overview:
- Control stage that wraps the SAR conversion FSM.
- Issues single-cycle start pulses to the SAR engine at a programmable interval and captures each finished result on the eoc rising edge.
- Accumulates 2^LOG2_AVG consecutive results and presents their truncated mean to the downstream consumer over a valid/ready handshake.
- Also flags averaged samples that are lost to consumer backpressure.

Parameters:
- WIDTH, 6, SAR result width in bits.
- LOG2_AVG, 2, log2 of the number of conversions averaged per output sample. Range 0..4.
- PERIOD_W, 16, width of the inter-conversion gap counter.

Ports:
- clk_i  input  1  system clock.
- rst_ni  input  1  reset. Asynchronous, active-low.
- en_i  input  1  enables continuous conversion sequencing.
- period_i  input  PERIOD_W  idle gap in cycles between one eoc rising edge and the next START state. Sampled on entry to GAP.
- sar_start_o  output  1  start pulse to the SAR FSM.
- sar_eoc_i  input  1  SAR end-of-conversion/idle level. High means the SAR is idle and result_o is valid.
- sar_result_i  input  WIDTH  SAR conversion result.
- data_o  output  WIDTH  averaged sample.
- valid_o  output  1  data_o holds an untransferred sample.
- ready_i  input  1  downstream accepts data_o.
- ovf_o  output  1  sticky flag: an averaged sample was dropped.
- clr_ovf_i  input  1  clears ovf_o.
- busy_o  output  1  FSM is not in IDLE.

Behaviour:
- Reset (rst_ni low, asynchronous):
  - All outputs are 0; FSM is in IDLE.
  - Accumulator, sample counter, gap counter and eoc_q (eoc delayed by one register) are 0.
- eoc rise: eoc_q = 0 and sar_eoc_i = 1 in the same cycle.
- Accumulator: WIDTH+LOG2_AVG bits wide; cannot overflow.
- Sample counter: LOG2_AVG bits wide, wraps to 0 after the last sample.
- FSM states:
  - IDLE: sar_start_o = 0.
    - en_i = 1 -> START.
  - START:
    - If sar_eoc_i = 1: assert sar_start_o for exactly this cycle, then -> CONV.
    - If sar_eoc_i = 0 (SAR still busy): hold in START with sar_start_o = 0.
    - en_i = 0 while in START -> IDLE, with no pulse.
  - CONV: wait for eoc rise. On the rise cycle:
    - If en_i = 1:
      - acc_next = acc + sar_result_i.
      - If this is the 2^LOG2_AVG-th sample: avg = acc_next >> LOG2_AVG (truncation), load the output stage, clear acc and counter.
      - Otherwise increment the counter.
      - Then -> GAP.
    - If en_i = 0: discard the result, clear acc and counter, -> IDLE. A conversion is never aborted mid-flight.
  - GAP: count period_i cycles; period_i = 0 means zero GAP cycles (direct to START next cycle).
    - At terminal count: en_i = 1 -> START, else -> IDLE.
    - en_i = 0 at any point during GAP -> IDLE immediately. Partial accumulation is cleared.
- Output stage:
  - Load takes effect at the clock edge following the eoc rise; valid_o = 1 and data_o = avg in the next cycle.
  - A transfer occurs on valid_o & ready_i. valid_o drops the following cycle unless a new load coincides.
  - Load while valid_o = 1 and ready_i = 0: new avg is dropped, data_o is unchanged, and ovf_o is set the next cycle.
  - Load in the same cycle as a transfer: the old sample transfers, the new one loads, valid_o stays 1, and ovf_o is unchanged.
- ovf_o: set has priority over clr_ovf_i when both occur in the same cycle.
- data_o is stable while valid_o = 1 and ready_i = 0.
- busy_o = 1 in START, CONV and GAP.
- Start-to-start spacing: conversion time + 1 + period_i cycles.

Test Plan:
- Reset mid-conversion: assert rst_ni low during CONV -> all outputs 0 immediately. After release with en_i = 1 -> first sar_start_o appears, and the accumulator restarts from 0.
- Basic averaging: LOG2_AVG = 2, period_i = 0, ready_i = 1, SAR model returns 10, 11, 12, 13 -> one valid_o pulse with data_o = 11 (46 >> 2). Exactly 4 sar_start_o pulses, each one cycle wide.
- Gap timing: period_i = 3 -> exactly 3 GAP cycles plus 1 START cycle between the eoc-rise cycle and the next sar_start_o. With period_i = 0 the spacing is 1 cycle.
- Backpressure: ready_i = 0 across two complete averages (63, 63, 63, 63 then 0, 0, 0, 0) -> data_o stays 63 and ovf_o = 1. clr_ovf_i pulse -> ovf_o = 0. ready_i = 1 -> one transfer of 63.
- Simultaneous load and transfer: ready_i rises on the same cycle the next average loads -> old value is transferred, new value appears with valid_o continuous, and ovf_o stays 0.
- Disable handling:
  - en_i dropped mid-CONV after 2 of 4 samples -> conversion completes, result discarded, FSM to IDLE, no valid_o.
  - Re-enable -> next output averages 4 fresh samples only.
  - en_i low during GAP -> IDLE next cycle, and no further sar_start_o.
